imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_SIZE, default 512, memory depth in words; IDX_W = clog2(MEM_SIZE).
REQ-004 SHALL have parameter STARVE_MAX, default 4, consecutive denied loader cycles before a forced loader grant.
REQ-005 SHALL have the port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have the port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have the port fetch_req, input, 1, core requests an instruction read.
REQ-008 SHALL have the port fetch_addr, input, ADDR_WIDTH, byte address of the read.
REQ-009 SHALL have the port fetch_gnt, output, 1, read accepted this cycle.
REQ-010 SHALL have the ports fetch_rvalid (output, 1) and fetch_rdata (output, DATA_WIDTH), the returned word.
REQ-011 SHALL have the ports load_req (input, 1), load_addr (input, ADDR_WIDTH) and load_wdata (input, DATA_WIDTH), a loader write request.
REQ-012 SHALL have the ports load_gnt (output, 1), write accepted, and load_done (input, 1), a one-cycle pulse marking the end of the boot image.
REQ-013 SHALL have the ports mem_addr (output, IDX_W), mem_we (output, 1), mem_wdata (output, DATA_WIDTH) and mem_rdata (input, DATA_WIDTH), a synchronous-read RAM with 1-cycle latency.
REQ-014 SHALL have the port cpu_hold, output, 1, which holds the core in reset until boot completes.
REQ-015 SHALL have the port addr_err, output, 1, sticky address-error flag.

Function
REQ-016 SHALL implement FSM states BOOT, DRAIN and RUN.
REQ-017 SHALL stay in BOOT with cpu_hold=1; in BOOT only loader requests are granted and fetch_gnt stays 0.
REQ-018 SHALL move from BOOT to DRAIN on load_done; a load_req in the same cycle is still granted.
REQ-019 SHALL spend exactly one cycle in DRAIN with no grants, then enter RUN.
REQ-020 SHALL deassert cpu_hold on the first RUN cycle.
REQ-021 SHALL give fetch priority in RUN: fetch_req implies fetch_gnt=1, and load_gnt=0 unless the starvation rule fires.
REQ-022 SHALL increment starve_cnt each RUN cycle in which load_req is denied, reset it on any load grant, and hold it otherwise.
REQ-023 SHALL, when starve_cnt==STARVE_MAX and load_req=1, grant the loader and deny fetch that cycle.
REQ-024 SHALL never assert both grants in the same cycle.
REQ-025 SHALL drive mem_addr = addr[IDX_W+1:2] of the granted requester; ignore addr[1:0]; mem_we = load_gnt.
REQ-026 SHALL assert fetch_rvalid exactly one cycle after fetch_gnt, with fetch_rdata = mem_rdata; otherwise fetch_rvalid=0.
REQ-027 SHALL perform back-to-back fetch grants every cycle, giving throughput of 1 word per cycle.
REQ-028 SHALL make grants combinational on the current-cycle requests, with the FSM and starve_cnt registered.
REQ-029 SHALL allow a RUN-phase loader write to the word being fetched in the same cycle only via the forced grant; fetch retries next cycle.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, set state=BOOT, starve_cnt=0, cpu_hold=1, fetch_rvalid=0 and addr_err=0.
REQ-031 SHALL keep grants and mem_we 0 during reset regardless of requests.
REQ-032 SHALL restart in BOOT after reset mid-RUN; a pending rvalid is dropped.

Configuration
REQ-033 SHALL, with macro IMEM_ARBITER_BOUNDS_CHK_EN defined, treat granted addresses with addr[ADDR_WIDTH-1:2] >= MEM_SIZE as follows: set addr_err (sticky until reset), suppress mem_we, and return fetch_rdata=32'h00000013 (NOP) on the rvalid cycle.
REQ-034 SHALL, without the macro, truncate addresses to IDX_W bits (wrap-around) and tie addr_err to 0.

Structure
REQ-035 SHALL place the FSM state enum, the NOP constant 32'h00000013 and the default STARVE_MAX in package imem_pkg.
REQ-036 SHALL implement the priority/starvation logic in one sub-module, imem_grant_arb; the FSM and data return stay in the top.

Verification
REQ-037 SHALL cover this scenario: reset, then loader writes 0x0-0xC with 4 words, then load_done, then fetch 0x4 -> cpu_hold falls 2 cycles after load_done, and fetch_rdata equals the second word one cycle after grant.
REQ-038 SHALL cover this scenario: fetch_req held during BOOT -> fetch_gnt=0 throughout, and no rvalid.
REQ-039 SHALL cover this scenario: RUN with fetch_req=1 every cycle and load_req=1 -> load_gnt exactly once per 5 cycles (STARVE_MAX=4), with the fetch denied that cycle.
REQ-040 SHALL cover this scenario: load_req and load_done in the same cycle -> the write is committed, then the DRAIN cycle has no grants.
REQ-041 SHALL cover this scenario: with the macro, fetch 0x800 (word 512) -> addr_err=1 and rdata=0x00000013; without the macro, word 0 is returned.
REQ-042 SHALL cover this scenario: rst_n low mid-RUN with a pending rvalid -> rvalid=0, cpu_hold=1 and state BOOT next cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSN           = 32'h00000013;
  localparam int          STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/imem_grant_arb.sv
// Fetch-priority arbiter with a loader anti-starvation counter.
module imem_grant_arb
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_boot,
  input  logic in_run,
  input  logic fetch_req,
  input  logic load_req,
  output logic fetch_gnt,
  output logic load_gnt
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_load;

  always_comb begin
    fetch_gnt  = 1'b0;
    load_gnt   = 1'b0;
    force_load = in_run && load_req && (starve_cnt == CNT_W'(STARVE_MAX));
    if (rst_n) begin
      if (in_boot) begin
        load_gnt = load_req;
      end else if (in_run) begin
        fetch_gnt = fetch_req && !force_load;
        load_gnt  = load_req && (force_load || !fetch_req);
      end
    end
  end

  // A forced grant clears the counter, so it never passes STARVE_MAX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (load_gnt) begin
      starve_cnt <= '0;
    end else if (in_run && load_req) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Boot/run arbiter between a core fetch port and a boot loader on one RAM.
// Optional bounds checking is enabled with macro IMEM_ARBITER_BOUNDS_CHK_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 32,
  parameter int  MEM_SIZE   = 512,
  parameter int  STARVE_MAX = STARVE_MAX_DEFAULT,
  localparam int IDX_W      = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_gnt,
  input  logic                  load_done,
  output logic [IDX_W-1:0]      mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold,
  output logic                  addr_err
);

  imem_state_e           state;
  logic                  in_boot;
  logic                  in_run;
  logic [ADDR_WIDTH-1:0] gnt_addr_p0;
  logic                  vld_p1;
  logic                  unused_addr_bits;

  assign in_boot = (state == ST_BOOT);
  assign in_run  = (state == ST_RUN);

  imem_grant_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_grant_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_boot  (in_boot),
    .in_run   (in_run),
    .fetch_req(fetch_req),
    .load_req (load_req),
    .fetch_gnt(fetch_gnt),
    .load_gnt (load_gnt)
  );

  // p0: grant, RAM address and write
  assign gnt_addr_p0      = load_gnt ? load_addr : fetch_addr;
  assign mem_addr         = gnt_addr_p0[IDX_W+1:2];
  assign mem_wdata        = load_wdata;
  assign unused_addr_bits = ^{gnt_addr_p0[1:0], gnt_addr_p0[ADDR_WIDTH-1:IDX_W+2]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      cpu_hold <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= fetch_gnt;
      case (state)
        ST_BOOT: begin
          if (load_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state    <= ST_RUN;
          cpu_hold <= 1'b0;
        end
        ST_RUN: ;
        default: begin
          state    <= ST_BOOT;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  // p1: read data return, one cycle after the fetch grant
  assign fetch_rvalid = vld_p1;

`ifdef IMEM_ARBITER_BOUNDS_CHK_EN
  logic oob_p0;
  logic oob_p1;
  logic addr_err_q;

  assign oob_p0 = gnt_addr_p0[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_SIZE);
  assign mem_we = load_gnt && !oob_p0;

  always_ff @(posedge clk) begin
    oob_p1 <= fetch_gnt && oob_p0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if ((fetch_gnt || load_gnt) && oob_p0) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err    = addr_err_q;
  assign fetch_rdata = oob_p1 ? DATA_WIDTH'(NOP_INSN) : mem_rdata;
`else
  assign mem_we      = load_gnt;
  assign addr_err    = 1'b0;
  assign fetch_rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a queue-based read-data scoreboard.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;
  logic        load_gnt;
  logic        load_done;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        cpu_hold;
  logic        addr_err;

  imem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_SIZE  (512),
    .STARVE_MAX(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata (fetch_rdata),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_wdata  (load_wdata),
    .load_gnt    (load_gnt),
    .load_done   (load_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .cpu_hold    (cpu_hold),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, 1-cycle latency
  logic [31:0] ram [0:511];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] d);
    sb.push_back('{data: d, due: cyc + 1});
  endtask

  // Monitor: every rvalid must match the oldest queued expectation on its due cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      total++;
      if (fetch_rvalid !== 1'b1 || fetch_rdata !== sb[0].data) begin
        bad++;
        $display("FAIL rdata: got vld=%b data=%0h want vld=1 data=%0h (cycle %0d)",
                 fetch_rvalid, fetch_rdata, sb[0].data, cyc);
      end
      void'(sb.pop_front());
    end else if (fetch_rvalid !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL rvalid_unexpected: got %b want 0 (cycle %0d)", fetch_rvalid, cyc);
    end
  end

  task automatic go(input logic rn, input logic fr, input logic [31:0] fa,
                    input logic lr, input logic [31:0] la, input logic [31:0] lw,
                    input logic ld);
    @(posedge clk);
    #1;
    rst_n      = rn;
    fetch_req  = fr;
    fetch_addr = fa;
    load_req   = lr;
    load_addr  = la;
    load_wdata = lw;
    load_done  = ld;
    @(negedge clk);
  endtask

  logic [31:0] boot_w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] b2b_a  [6] = '{32'h0, 32'h8, 32'hC, 32'h10, 32'h7, 32'h20};
  logic [31:0] b2b_d  [6] = '{32'h11111111, 32'h33333333, 32'h44444444,
                              32'h55555555, 32'h22222222, 32'h0};

  initial begin
    logic [31:0] cur;
    logic        exp_ld;

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_req = 1'b0;
    load_addr = '0; load_wdata = '0; load_done = 1'b0;

    // Reset with both requesters active: nothing granted
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'hDEAD, 1'b0);
      check("reset_outputs", {fetch_gnt, load_gnt, mem_we, cpu_hold, fetch_rvalid, addr_err},
            6'b000100);
    end

    // BOOT: loader writes words 0..3 while fetch is held requesting
    for (int i = 0; i < 4; i++) begin
      go(1'b1, 1'b1, 32'h4, 1'b1, 32'(4 * i), boot_w[i], 1'b0);
      check("boot_grants", {fetch_gnt, load_gnt, mem_we, cpu_hold}, 4'b0111);
      check("boot_mem_addr", mem_addr, 64'(i));
    end

    // load_done with a write in the same cycle: the write still lands
    go(1'b1, 1'b1, 32'h4, 1'b1, 32'h10, 32'h55555555, 1'b1);
    check("done_cycle_grants", {fetch_gnt, load_gnt, mem_we}, 3'b011);
    check("done_cycle_mem_addr", mem_addr, 64'd4);

    // DRAIN: no grants, core still held
    go(1'b1, 1'b1, 32'h4, 1'b1, 32'h20, 32'h66666666, 1'b0);
    check("drain_grants", {fetch_gnt, load_gnt, mem_we, cpu_hold}, 4'b0001);

    // First RUN cycle: hold released, fetch 0x4 granted
    go(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    check("run_first", {fetch_gnt, load_gnt, cpu_hold}, 3'b100);
    expect_fetch(32'h22222222);

    // Back-to-back fetches, including an unaligned address and the word DRAIN refused
    for (int i = 0; i < 6; i++) begin
      go(1'b1, 1'b1, b2b_a[i], 1'b0, 32'h0, 32'h0, 1'b0);
      check("b2b_gnt", {fetch_gnt, load_gnt}, 2'b10);
      check("b2b_mem_addr", mem_addr, 64'(b2b_a[i][10:2]));
      expect_fetch(b2b_d[i]);
    end

    // Starvation: fetch and loader both hammer word 2; loader wins every 5th cycle
    cur = 32'h33333333;
    for (int k = 0; k < 10; k++) begin
      go(1'b1, 1'b1, 32'h8, 1'b1, 32'h8, 32'hA0000000 | 32'(k), 1'b0);
      exp_ld = ((k % 5) == 4);
      check("starve_grants", {fetch_gnt, load_gnt, mem_we}, {!exp_ld, exp_ld, exp_ld});
      if (exp_ld) cur = 32'hA0000000 | 32'(k);
      else        expect_fetch(cur);
    end

    // Idle fetch in RUN: loader granted immediately
    go(1'b1, 1'b0, 32'h0, 1'b1, 32'h30, 32'h77777777, 1'b0);
    check("run_idle_load", {fetch_gnt, load_gnt, mem_we}, 3'b011);

    // Fetch beyond the memory
    go(1'b1, 1'b1, 32'h800, 1'b0, 32'h0, 32'h0, 1'b0);
    check("oob_fetch_gnt", {fetch_gnt, mem_addr}, {1'b1, 9'd0});
`ifdef IMEM_ARBITER_BOUNDS_CHK_EN
    expect_fetch(32'h00000013);
`else
    expect_fetch(32'h11111111);
`endif
    go(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef IMEM_ARBITER_BOUNDS_CHK_EN
    check("oob_addr_err", addr_err, 64'd1);
`else
    check("oob_addr_err", addr_err, 64'd0);
`endif

    // Reset mid-RUN right after a grant
    go(1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0, 1'b0);
    check("pre_reset_gnt", fetch_gnt, 64'd1);
    expect_fetch(32'h44444444);
    go(1'b0, 1'b1, 32'hC, 1'b1, 32'h0, 32'hBBBBBBBB, 1'b0);
    check("mid_reset_grants", {fetch_gnt, load_gnt, mem_we}, 3'b000);
    go(1'b1, 1'b1, 32'hC, 1'b1, 32'h0, 32'hBBBBBBBB, 1'b0);
    check("post_reset_boot", {fetch_rvalid, cpu_hold, fetch_gnt, load_gnt}, 4'b0101);
    check("post_reset_addr_err", addr_err, 64'd0);

    go(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    go(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
